// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word reads over a req/ready
// handshake and holds one decoded-ready instruction for the datapath.
module fetch_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            stall,
  output logic            instr_valid,
  output logic [XLEN-1:0] Instr,
  output logic [6:0]      op,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4
);

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] VALID = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pco_q, pco_d;
  logic [XLEN-1:0] pcp4_q, pcp4_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] tgt;

  assign tgt = {redirect_target[XLEN-1:2], 2'b00};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    instr_d = instr_q;
    pco_d   = pco_q;
    pcp4_d  = pcp4_q;
    kill_d  = kill_q;
    unique case (state_q)
      BOOT: begin
        pc_d    = redirect ? tgt : pc_q;
        addr_d  = pc_d;
        req_d   = 1'b1;
        state_d = FETCH;
      end
      FETCH: begin
        if (imem_ready) begin
          // a killed or same-cycle-redirected response is dropped
          if (kill_q || redirect) begin
            pc_d   = redirect ? tgt : pc_q;
            addr_d = pc_d;
            kill_d = 1'b0;
          end else begin
            instr_d = imem_rdata;
            pco_d   = pc_q;
            pcp4_d  = pc_q + XLEN'(4);
            valid_d = 1'b1;
            pc_d    = pc_q + XLEN'(4);
            req_d   = 1'b0;
            state_d = VALID;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
          pc_d   = tgt;
        end
      end
      VALID: begin
        if (redirect) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          pc_d    = tgt;
          addr_d  = tgt;
          req_d   = 1'b1;
          state_d = FETCH;
        end else if (!stall) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          addr_d  = pc_q;
          req_d   = 1'b1;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = BOOT;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pco_q   <= RESET_PC;
      pcp4_q  <= RESET_PC + XLEN'(4);
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      pco_q   <= pco_d;
      pcp4_q  <= pcp4_d;
      kill_q  <= kill_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr_valid = valid_q;
  assign Instr       = instr_q;
  assign op          = instr_q[6:0];
  assign funct3      = instr_q[14:12];
  assign funct7      = instr_q[31:25];
  assign PC          = pco_q;
  assign PCPlus4     = pcp4_q;

endmodule
